seg_scan_monitor: RTL



---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_pattern_decoder.sv | 17 +
 rtl/seg_scan_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan monitor and the
// display driver's encoder.
//   SEG_HEX_TABLE : active-low gfedcba glyphs for hex digits 0..F
//   scan_state_e  : capture FSM states of the scan monitor
//   seg_to_hex()  : active-low cathode pattern -> {valid, nibble}
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } scan_state_e;

  // Index k holds the active-low pattern that displays hex digit k.
  localparam logic [6:0] SEG_HEX_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Returns {1'b1, nibble} for a known glyph, 5'b0 for anything else.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] result;
    result = 5'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg == SEG_HEX_TABLE[k]) begin
        result = {1'b1, 4'(k)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: combinational glyph decoder.
//   seg    in  7  active-low cathode pattern, bit0 = a ... bit6 = g
//   valid  out 1  pattern is one of the 16 hex glyphs
//   nibble out 4  decoded hex value, 0 when valid is low
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    {valid, nibble} = seg_to_hex(seg);
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// seg_scan_monitor: receive side of a multiplexed seven-segment scan bus.
// Rebuilds per-digit hex values, decimal points and frame boundaries from
// a rotating one-hot-low anode select.
//   clk_i          in   system clock
//   reset_i        in   synchronous active-high reset
//   an_i           in   anode selects, active low
//   seg_i          in   cathodes, active low (bit0 = a ... bit6 = g)
//   dp_i           in   decimal point, active low
//   digits_o       out  decoded nibbles, digit i at [4i+3:4i]
//   dp_o           out  captured decimal points, active high
//   invalid_o      out  digit i's last captured pattern was not a hex glyph
//   frame_valid_o  out  pulse: every digit captured in scan order
//   seq_err_o      out  pulse: capture out of scan order
//   anode_err_o    out  pulse: stable anode vector with several bits low
module seg_scan_monitor
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  input  logic                    dp_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic [NUM_DIGITS-1:0]   invalid_o,
  output logic                    frame_valid_o,
  output logic                    seq_err_o,
  output logic                    anode_err_o
);

  localparam int                IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]        SETTLE_TARGET = 8'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(NUM_DIGITS - 1);

  function automatic logic is_one_low(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] low;
    low = ~an;
    return (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
  endfunction

  // Registered bus sample
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;

  logic [7:0]            cnt_reg;
  logic [7:0]            cnt_next;
  scan_state_e           state_reg;

  logic [NUM_DIGITS-1:0] seen_reg;
  logic                  expect_valid_reg;
  logic [IDX_W-1:0]      last_idx_reg;

  logic                  frame_reg;
  logic                  seq_err_reg;
  logic                  anode_err_reg;

  logic [3:0]            nibble_reg  [NUM_DIGITS];
  logic                  dp_cap_reg  [NUM_DIGITS];
  logic                  invalid_reg [NUM_DIGITS];

  logic                  sample_same;
  logic                  an_changed;
  logic                  settle_hit;
  logic                  an_one_low;
  logic                  an_illegal;
  logic                  capture;
  logic                  in_order;
  logic [IDX_W-1:0]      cap_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] seen_merged;

  logic                  dec_valid;
  logic [3:0]            dec_nibble;

  seg7_pattern_decoder u_decoder (
    .seg    (seg_reg),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  always_comb begin
    // The incoming bus is compared against the registered sample, so the
    // counter restarts on the same edge at which a new value is registered.
    // A change arriving on what would be the capture edge kills settle_hit.
    sample_same = (an_i == an_reg) && (seg_i == seg_reg) && (dp_i == dp_reg);
    an_changed  = (an_i != an_reg);

    if (!sample_same) begin
      cnt_next = '0;
    end else if (cnt_reg == SETTLE_TARGET) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end

    // True only on the edge where the counter reaches the target, so each
    // stable run produces at most one hit.
    settle_hit = sample_same && (cnt_reg == SETTLE_TARGET - 8'd1);

    an_one_low = is_one_low(an_reg);
    an_illegal = !an_one_low && !(&an_reg);
    capture    = (state_reg == SETTLE) && settle_hit && an_one_low;

    cap_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_reg[k]) begin
        cap_idx = IDX_W'(k);
      end
    end

    next_idx    = (last_idx_reg == LAST_IDX) ? '0 : last_idx_reg + IDX_W'(1);
    in_order    = !expect_valid_reg || (cap_idx == next_idx);
    seen_merged = seen_reg | ~an_reg;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // Sample resets to a blank bus so a live anode re-settles from scratch.
      an_reg           <= '1;
      seg_reg          <= '1;
      dp_reg           <= 1'b1;
      cnt_reg          <= '0;
      state_reg        <= IDLE;
      seen_reg         <= '0;
      expect_valid_reg <= 1'b0;
      last_idx_reg     <= '0;
      frame_reg        <= 1'b0;
      seq_err_reg      <= 1'b0;
      anode_err_reg    <= 1'b0;
    end else begin
      an_reg        <= an_i;
      seg_reg       <= seg_i;
      dp_reg        <= dp_i;
      cnt_reg       <= cnt_next;
      frame_reg     <= 1'b0;
      seq_err_reg   <= 1'b0;
      anode_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (is_one_low(an_i)) begin
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          if (an_changed) begin
            state_reg <= is_one_low(an_i) ? SETTLE : IDLE;
          end else if (capture) begin
            state_reg <= HELD;
          end
        end
        HELD: begin
          // Cathode-only changes are ignored until the anode moves.
          if (an_changed) begin
            state_reg <= is_one_low(an_i) ? SETTLE : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (capture) begin
        last_idx_reg <= cap_idx;
        if (!in_order) begin
          // Restart frame accumulation at this digit; the next capture is
          // accepted unconditionally, as after any other error.
          seq_err_reg      <= 1'b1;
          seen_reg         <= ~an_reg;
          expect_valid_reg <= 1'b0;
        end else begin
          expect_valid_reg <= 1'b1;
          if (&seen_merged) begin
            frame_reg <= 1'b1;
            seen_reg  <= '0;
          end else begin
            seen_reg  <= seen_merged;
          end
        end
      end

      if (settle_hit && an_illegal) begin
        anode_err_reg    <= 1'b1;
        seen_reg         <= '0;
        expect_valid_reg <= 1'b0;
        state_reg        <= IDLE;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          nibble_reg[gi]  <= '0;
          dp_cap_reg[gi]  <= 1'b0;
          invalid_reg[gi] <= 1'b0;
        end else if (capture && !an_reg[gi]) begin
          nibble_reg[gi]  <= dec_nibble;
          dp_cap_reg[gi]  <= ~dp_reg;
          invalid_reg[gi] <= ~dec_valid;
        end
      end

      assign digits_o[4*gi +: 4] = nibble_reg[gi];
      assign dp_o[gi]            = dp_cap_reg[gi];
      assign invalid_o[gi]       = invalid_reg[gi];
    end
  endgenerate

  assign frame_valid_o = frame_reg;
  assign seq_err_o     = seq_err_reg;
  assign anode_err_o   = anode_err_reg;

endmodule
